aer_event_buffer: RTL and testbench
===================================

Name: aer_event_buffer

Overview:
- Parametrised successor to the fixed-delay single-wire AER buffer.
- Receives address-events on an asynchronous 4-phase req/ack AER input, synchronises the handshake and stores events in a DEPTH-entry FIFO.
- Re-emits stored events on a 4-phase AER output with a programmable minimum inter-event gap.
- Sits between a sender chip/array and a downstream AER receiver; decouples their handshakes and absorbs bursts.

Parameters:
- ADDR_W, 8: event address width in bits.
- DEPTH, 16: FIFO entries; power of 2, at least 2.
- SYNC_STAGES, 2: flops in each handshake synchroniser (req_in, ack_out); at least 2.
- GAP_CYCLES, 0: minimum clk cycles from ack_out falling (synced) to the next req_out rising, beyond base latency.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_in  in  1  sender request; asynchronous, synchronised internally.
- addr_in  in  ADDR_W  sender address; bundled data, stable while req_in is high.
- ack_in  out  1  acknowledge to sender.
- req_out  out  1  request to receiver.
- addr_out  out  ADDR_W  address to receiver; registered.
- ack_out  in  1  receiver acknowledge; asynchronous, synchronised internally.
- fifo_count  out  $clog2(DEPTH)+1  stored events.
- fifo_full  out  1  fifo_count == DEPTH.
- fifo_empty  out  1  fifo_count == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ack_in=0, req_out=0, addr_out=0, fifo_count=0, fifo_full=0, fifo_empty=1. Both FSMs go to IDLE, the gap counter clears, and the synchroniser flops clear.
- Input FSM, IN_IDLE:
  - If req_s=1 and !fifo_full: write addr_in into the FIFO, set ack_in=1, go to IN_ACK.
  - If req_s=1 and full: hold with ack_in=0. This is backpressure; events are never dropped.
- Input FSM, IN_ACK: when req_s=0, set ack_in=0 and go to IN_IDLE.
- Input latency: req_in rising to ack_in rising is SYNC_STAGES+1 edges (3 at default).
- Output FSM, OUT_IDLE: if !fifo_empty and gap_cnt==0, load addr_out from the FIFO head and go to OUT_SETUP.
- Output FSM, OUT_SETUP: one cycle with addr_out valid and req_out=0. Then set req_out=1 and go to OUT_REQ.
- Output FSM, OUT_REQ: when ack_s=1, pop the FIFO, set req_out=0, go to OUT_REL.
- Output FSM, OUT_REL: when ack_s=0, load gap_cnt=GAP_CYCLES and go to OUT_IDLE. gap_cnt decrements to 0 each cycle while nonzero.
- addr_out holds its last value until the next OUT_SETUP.
- Pass-through latency, empty FIFO and gap expired: req_out rises 2 edges after the FIFO write, i.e. SYNC_STAGES+3 edges after req_in rises (5 at default).
- FIFO pointers: ADDR bits + 1 wrap bit; wrap-around is modulo DEPTH. Full and empty are derived from the registered count.
- Simultaneous write and pop: both are performed and the count is unchanged.
- A write is gated by the registered fifo_full. A pop in the same cycle does not admit a write when full; the write happens the next cycle.
- Ordering: strict FIFO.
- Reset mid-operation, input side: stored events are discarded.
  - If req_in is still high after reset, IN_IDLE re-accepts it as a new event.
  - The sender then sees ack_in fall and rise, completing normally.
- Reset mid-operation, output side: req_out drops immediately on reset. The receiver must tolerate an aborted handshake.
- No combinational path from any input to any output.

Decomposition:
- Package aer_pkg holds:
  - the in_state_t enum: IN_IDLE, IN_ACK;
  - the out_state_t enum: OUT_IDLE, OUT_SETUP, OUT_REQ, OUT_REL;
  - helper localparams: PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1.
- Sub-module aer_sync (parameter STAGES, 1-bit, synchronous reset to 0), instantiated twice: req_in to req_s, and ack_out to ack_s.
- FIFO storage and pointers stay inline.

Test Plan:
- Single event:
  - Stimulus: default params; req_in rises with addr_in=8'hA5; the bench receiver acks 2 cycles after req_out.
  - Response: ack_in rises at edge 3; req_out rises at edge 5 with addr_out=8'hA5; fifo_count goes 1 then 0.
- Burst to full:
  - Stimulus: DEPTH=4; ack_out held low; 5 events 8'h01..8'h05.
  - Response: 4 events acknowledged; fifo_full=1 and ack_in stays 0 on event 5.
  - Then release ack_out: output order is 01,02,03,04,05, and event 5 is acked after the first pop.
- Simultaneous read/write:
  - Stimulus: fifo_count=2; an input write and an output pop land on the same edge.
  - Response: fifo_count stays 2 and data order is preserved.
- Gap enforcement:
  - Stimulus: GAP_CYCLES=6; 3 back-to-back stored events.
  - Response: between ack_s falling and the next req_out rising, at least 6+2 cycles elapse.
- Pointer wrap:
  - Stimulus: DEPTH=4; stream 10 events with random ack delays of 0-5 cycles.
  - Response: all 10 events delivered in order; fifo_count never exceeds 4.
- Reset mid-handshake:
  - Stimulus: assert rst for 1 cycle while in OUT_REQ with fifo_count=3 and req_in high.
  - Response: the next cycle has req_out=0, fifo_empty=1, ack_in=0.
  - After reset, the held req_in is re-accepted: ack_in rises SYNC_STAGES+1 edges later and fifo_count=1.

Source files
------------

// File: rtl/aer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aer_pkg : state encodings and sizing helpers for the AER event buffer
// Rev 1.0
// ---------------------------------------------------------------------------
package aer_pkg;

  typedef enum logic [0:0] {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE  = 2'd0,
    OUT_SETUP = 2'd1,
    OUT_REQ   = 2'd2,
    OUT_REL   = 2'd3
  } out_state_t;

  // Sizes for the default 16-entry configuration; ptr_width() resizes per instance.
  localparam int DEPTH_DEFAULT = 16;
  localparam int PTR_W = $clog2(DEPTH_DEFAULT);
  localparam int CNT_W = PTR_W + 1;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aer_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aer_sync : multi-flop synchroniser for one asynchronous handshake line
// Rev 1.0
// ---------------------------------------------------------------------------
module aer_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/aer_event_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aer_event_buffer : 4-phase AER in -> FIFO -> 4-phase AER out with min gap
// Rev 1.0
// ---------------------------------------------------------------------------
module aer_event_buffer
  import aer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [ADDR_W-1:0]        addr_in,
  output logic                     ack_in,
  output logic                     req_out,
  output logic [ADDR_W-1:0]        addr_out,
  input  logic                     ack_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  localparam int PW       = ptr_width(DEPTH);
  localparam int CW       = PW + 1;
  localparam int PTR_BITS = PW + 1;
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic              req_s, ack_s;
  in_state_t         in_state, in_next;
  out_state_t        out_state, out_next;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [GW-1:0]     gap_cnt;
  logic              wr_en, pop, load_addr, load_gap;
  logic              ack_in_next, req_out_next;

  aer_sync #(.STAGES(SYNC_STAGES)) u_req_sync (.clk(clk), .rst(rst), .d(req_in),  .q(req_s));
  aer_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (.clk(clk), .rst(rst), .d(ack_out), .q(ack_s));

  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // Input side: a full FIFO simply withholds ack_in, so the sender stalls.
  always_comb begin
    in_next     = in_state;
    wr_en       = 1'b0;
    ack_in_next = ack_in;
    case (in_state)
      IN_IDLE: if (req_s && !fifo_full) begin
        wr_en       = 1'b1;
        ack_in_next = 1'b1;
        in_next     = IN_ACK;
      end
      IN_ACK: if (!req_s) begin
        ack_in_next = 1'b0;
        in_next     = IN_IDLE;
      end
      default: in_next = IN_IDLE;
    endcase
  end

  always_comb begin
    out_next     = out_state;
    pop          = 1'b0;
    load_addr    = 1'b0;
    load_gap     = 1'b0;
    req_out_next = req_out;
    case (out_state)
      OUT_IDLE: if (!fifo_empty && gap_cnt == '0) begin
        load_addr = 1'b1;
        out_next  = OUT_SETUP;
      end
      OUT_SETUP: begin
        req_out_next = 1'b1;
        out_next     = OUT_REQ;
      end
      OUT_REQ: if (ack_s) begin
        pop          = 1'b1;
        req_out_next = 1'b0;
        out_next     = OUT_REL;
      end
      OUT_REL: if (!ack_s) begin
        load_gap = 1'b1;
        out_next = OUT_IDLE;
      end
      default: out_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state   <= IN_IDLE;
      out_state  <= OUT_IDLE;
      ack_in     <= 1'b0;
      req_out    <= 1'b0;
      addr_out   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      gap_cnt    <= '0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      ack_in    <= ack_in_next;
      req_out   <= req_out_next;
      if (load_addr) addr_out <= mem[rd_ptr[PW-1:0]];
      if (wr_en)     wr_ptr   <= wr_ptr + PTR_BITS'(1);
      if (pop)       rd_ptr   <= rd_ptr + PTR_BITS'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (load_gap)             gap_cnt <= GW'(GAP_CYCLES);
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= addr_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_aer_event_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aer_event_buffer : scoreboard bench for aer_event_buffer (DEPTH=4 and GAP=6 instances)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_aer_event_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_in, ack_in, req_out, ack_out, fifo_full, fifo_empty;
  logic [7:0] addr_in, addr_out;
  logic [2:0] fifo_count;

  logic       gap_req_in, gap_ack_in, gap_req_out, gap_ack_out, gap_full, gap_empty;
  logic [7:0] gap_addr_in, gap_addr_out;
  logic [4:0] gap_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int rx_count = 0;
  bit rx_en = 1'b0;
  bit rx_rand = 1'b0;
  bit rx_seen = 1'b0;
  int rx_delay = 2;
  int rx_wait = 0;
  int cyc = 0;
  int max_count = 0;

  aer_event_buffer #(.ADDR_W(8), .DEPTH(4), .SYNC_STAGES(2), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .ack_in(ack_in),
    .req_out(req_out), .addr_out(addr_out), .ack_out(ack_out),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  aer_event_buffer #(.ADDR_W(8), .DEPTH(16), .SYNC_STAGES(2), .GAP_CYCLES(6)) dut_gap (
    .clk(clk), .rst(rst), .req_in(gap_req_in), .addr_in(gap_addr_in), .ack_in(gap_ack_in),
    .req_out(gap_req_out), .addr_out(gap_addr_out), .ack_out(gap_ack_out),
    .fifo_count(gap_count), .fifo_full(gap_full), .fifo_empty(gap_empty)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (int'(fifo_count) > max_count) max_count = int'(fifo_count);

  // Receiver model: checks each new request against the scoreboard head.
  initial begin
    logic [7:0] exp;
    ack_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (req_out !== 1'b1) begin
        rx_seen = 1'b0;
        if (ack_out) ack_out = 1'b0;
      end else if (!ack_out) begin
        if (!rx_seen) begin
          rx_seen = 1'b1;
          rx_count++;
          rx_wait = rx_rand ? int'($urandom_range(0, 5)) : rx_delay;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected addr_out=%h expected none", addr_out);
          end else begin
            exp = sb.pop_front();
            if (addr_out !== exp) begin
              failures++;
              $display("FAIL rx_order addr_out=%h expected %h", addr_out, exp);
            end
          end
        end
        if (rx_en) begin
          if (rx_wait == 0) ack_out = 1'b1;
          else rx_wait--;
        end
      end
    end
  end

  task automatic send_event(input logic [7:0] a);
    int n;
    addr_in = a;
    req_in  = 1'b1;
    sb.push_back(a);
    n = 0;
    while (ack_in !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    checks++;
    if (ack_in !== 1'b1) begin failures++; $display("FAIL send_ack addr=%h ack_in=%b expected 1", a, ack_in); end
    req_in = 1'b0;
    n = 0;
    while (ack_in !== 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
    checks++;
    if (ack_in !== 1'b0) begin failures++; $display("FAIL send_release addr=%h ack_in=%b expected 0", a, ack_in); end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(fifo_empty === 1'b1 && req_out === 1'b0 && ack_out === 1'b0 && ack_in === 1'b0) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL %s_idle fifo_count=%0d req_out=%b ack_in=%b expected drained", tag, fifo_count, req_out, ack_in);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (ack_in !== 1'b0)        begin failures++; $display("FAIL reset_ack_in got=%b exp=0", ack_in); end
    if (req_out !== 1'b0)       begin failures++; $display("FAIL reset_req_out got=%b exp=0", req_out); end
    if (addr_out !== 8'h00)     begin failures++; $display("FAIL reset_addr_out got=%h exp=00", addr_out); end
    if (fifo_count !== 3'd0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    if (fifo_full !== 1'b0)     begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    if (fifo_empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    if (gap_req_out !== 1'b0)   begin failures++; $display("FAIL reset_gap_req_out got=%b exp=0", gap_req_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_event();
    int n;
    rx_en = 1'b1;
    rx_delay = 2;
    addr_in = 8'hA5;
    req_in  = 1'b1;
    sb.push_back(8'hA5);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        checks++;
        if (ack_in !== 1'b0) begin failures++; $display("FAIL single_ack_early edge=2 got=%b exp=0", ack_in); end
      end
      if (e == 3) begin
        checks += 2;
        if (ack_in !== 1'b1)     begin failures++; $display("FAIL single_ack_edge3 got=%b exp=1", ack_in); end
        if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", fifo_count); end
      end
      if (e == 4) begin
        checks++;
        if (req_out !== 1'b0) begin failures++; $display("FAIL single_req_early edge=4 got=%b exp=0", req_out); end
      end
      if (e == 5) begin
        checks += 2;
        if (req_out !== 1'b1)   begin failures++; $display("FAIL single_req_edge5 got=%b exp=1", req_out); end
        if (addr_out !== 8'hA5) begin failures++; $display("FAIL single_addr got=%h exp=a5", addr_out); end
      end
    end
    n = 0;
    while (fifo_count !== 3'd0 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", fifo_count); end
    req_in = 1'b0;
    wait_idle("single");
  endtask

  task automatic test_burst_full();
    int base, n;
    bit seen;
    base = rx_count;
    rx_en = 1'b0;
    for (int i = 1; i <= 4; i++) send_event(8'(i));
    checks += 2;
    if (fifo_full !== 1'b1)  begin failures++; $display("FAIL burst_full got=%b exp=1", fifo_full); end
    if (fifo_count !== 3'd4) begin failures++; $display("FAIL burst_count4 got=%0d exp=4", fifo_count); end
    addr_in = 8'h05;
    req_in  = 1'b1;
    sb.push_back(8'h05);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (ack_in) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL burst_backpressure ack_in_seen=%b exp=0", seen); end
    rx_delay = 1;
    rx_en = 1'b1;
    n = 0;
    while (ack_in !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks += 3;
    if (ack_in !== 1'b1)        begin failures++; $display("FAIL burst_ev5_ack got=%b exp=1", ack_in); end
    if (rx_count - base != 1)   begin failures++; $display("FAIL burst_ev5_after_first_pop delivered=%0d exp=1", rx_count - base); end
    if (fifo_count !== 3'd4)    begin failures++; $display("FAIL burst_ev5_count got=%0d exp=4", fifo_count); end
    req_in = 1'b0;
    wait_idle("burst");
    checks += 2;
    if (rx_count - base != 5) begin failures++; $display("FAIL burst_delivered got=%0d exp=5", rx_count - base); end
    if (sb.size() != 0)       begin failures++; $display("FAIL burst_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_simultaneous();
    int n;
    rx_en = 1'b0;
    send_event(8'h3C);
    send_event(8'hC3);
    n = 0;
    while (req_out !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (req_out !== 1'b1)    begin failures++; $display("FAIL simul_req got=%b exp=1", req_out); end
    if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_pre_count got=%0d exp=2", fifo_count); end
    addr_in = 8'h99;
    req_in  = 1'b1;
    sb.push_back(8'h99);
    ack_out = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin
        checks += 3;
        if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d exp=2", fifo_count); end
        if (ack_in !== 1'b1)     begin failures++; $display("FAIL simul_write got=%b exp=1", ack_in); end
        if (req_out !== 1'b0)    begin failures++; $display("FAIL simul_pop got=%b exp=0", req_out); end
      end
    end
    rx_delay = 0;
    rx_en = 1'b1;
    req_in = 1'b0;
    wait_idle("simul");
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL simul_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_wrap();
    int base;
    base = rx_count;
    max_count = 0;
    rx_en = 1'b1;
    rx_rand = 1'b1;
    for (int i = 0; i < 10; i++) send_event(8'h40 + 8'(i));
    wait_idle("wrap");
    rx_rand = 1'b0;
    checks += 3;
    if (rx_count - base != 10) begin failures++; $display("FAIL wrap_delivered got=%0d exp=10", rx_count - base); end
    if (max_count > 4)         begin failures++; $display("FAIL wrap_max_count got=%0d exp<=4", max_count); end
    if (sb.size() != 0)        begin failures++; $display("FAIL wrap_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_gap();
    int n, t_fall;
    logic [7:0] exp;
    gap_ack_out = 1'b0;
    t_fall = 0;
    for (int i = 0; i < 3; i++) begin
      gap_addr_in = 8'h70 + 8'(i);
      gap_req_in  = 1'b1;
      n = 0;
      while (gap_ack_in !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      gap_req_in = 1'b0;
      n = 0;
      while (gap_ack_in !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    end
    checks++;
    if (gap_count !== 5'd3) begin failures++; $display("FAIL gap_stored got=%0d exp=3", gap_count); end
    for (int i = 0; i < 3; i++) begin
      exp = 8'h70 + 8'(i);
      n = 0;
      while (gap_req_out !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (gap_req_out !== 1'b1 || gap_addr_out !== exp) begin
        failures++;
        $display("FAIL gap_event%0d req=%b addr=%h exp req=1 addr=%h", i, gap_req_out, gap_addr_out, exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc - t_fall < 10) begin failures++; $display("FAIL gap_spacing%0d got=%0d cycles exp>=10", i, cyc - t_fall); end
      end
      gap_ack_out = 1'b1;
      n = 0;
      while (gap_req_out !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
      gap_ack_out = 1'b0;
      t_fall = cyc;
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    rx_en = 1'b0;
    send_event(8'hD1);
    send_event(8'hD2);
    send_event(8'hD3);
    n = 0;
    while (req_out !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (req_out !== 1'b1)    begin failures++; $display("FAIL rstmid_req got=%b exp=1", req_out); end
    if (fifo_count !== 3'd3) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=3", fifo_count); end
    addr_in = 8'hD4;
    req_in  = 1'b1;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    sb.push_back(8'hD4);
    checks += 4;
    if (req_out !== 1'b0)    begin failures++; $display("FAIL rstmid_req_drop got=%b exp=0", req_out); end
    if (fifo_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", fifo_empty); end
    if (ack_in !== 1'b0)     begin failures++; $display("FAIL rstmid_ack got=%b exp=0", ack_in); end
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        checks++;
        if (ack_in !== 1'b0) begin failures++; $display("FAIL rstmid_ack_early got=%b exp=0", ack_in); end
      end
      if (e == 3) begin
        checks += 2;
        if (ack_in !== 1'b1)     begin failures++; $display("FAIL rstmid_reaccept got=%b exp=1", ack_in); end
        if (fifo_count !== 3'd1) begin failures++; $display("FAIL rstmid_count1 got=%0d exp=1", fifo_count); end
      end
    end
    rx_en = 1'b1;
    req_in = 1'b0;
    wait_idle("rstmid");
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rstmid_sb_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req_in = 1'b0;
    addr_in = 8'h00;
    gap_req_in = 1'b0;
    gap_addr_in = 8'h00;
    gap_ack_out = 1'b0;
    test_reset();
    test_single_event();
    test_burst_full();
    test_simultaneous();
    test_wrap();
    test_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
